// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Length-prefixed byte-stream loader that writes little-endian
//               words into instruction memory and holds the core in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] loaded_words
);

  localparam logic [2:0] c_stHdr0  = 3'd0;
  localparam logic [2:0] c_stHdr1  = 3'd1;
  localparam logic [2:0] c_stData  = 3'd2;
  localparam logic [2:0] c_stDone  = 3'd3;
  localparam logic [2:0] c_stError = 3'd4;

  // Idle counter only has to reach TIMEOUT-1; the next idle cycle is the timeout.
  localparam int                  c_IDLE_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
  localparam logic [31:0]         c_DEPTH     = 32'(DEPTH_WORDS);

  logic [2:0]          r_state;
  logic [2:0]          w_nextState;
  logic [15:0]         r_count;
  logic [1:0]          r_byteCnt;
  logic [23:0]         r_word;
  logic [c_IDLE_W-1:0] r_idle;
  logic [15:0]         r_loaded;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_coreRst;
  logic                r_done;
  logic                r_error;

  logic                w_ready;
  logic                w_transfer;
  logic                w_inTimedState;
  logic                w_lastByte;
  logic                w_timedOut;
  logic [15:0]         w_fullCount;
  logic [15:0]         w_loadedNext;

  assign w_transfer     = byte_valid & w_ready;
  assign w_inTimedState = (r_state == c_stHdr1) || (r_state == c_stData);
  assign w_lastByte     = (r_state == c_stData) && w_transfer && (r_byteCnt == 2'd3);
  assign w_timedOut     = w_inTimedState && !w_transfer && (r_idle == c_IDLE_LAST);
  assign w_fullCount    = {byte_data, r_count[7:0]};
  assign w_loadedNext   = r_loaded + 16'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_stHdr0;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_stHdr0: begin
        if (w_transfer) begin
          w_nextState = c_stHdr1;
        end
      end
      c_stHdr1: begin
        if (w_transfer) begin
          if (w_fullCount == 16'd0) begin
            w_nextState = c_stDone;
          end else if ({16'd0, w_fullCount} > c_DEPTH) begin
            w_nextState = c_stError;
          end else begin
            w_nextState = c_stData;
          end
        end else if (w_timedOut) begin
          w_nextState = c_stError;
        end
      end
      c_stData: begin
        if (w_lastByte && (w_loadedNext == r_count)) begin
          w_nextState = c_stDone;
        end else if (w_timedOut) begin
          w_nextState = c_stError;
        end
      end
      c_stDone:  w_nextState = c_stDone;
      c_stError: w_nextState = c_stError;
      default:   w_nextState = c_stError;
    endcase
  end

  // Output decode
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      c_stHdr0, c_stHdr1, c_stData: w_ready = 1'b1;
      default:                      w_ready = 1'b0;
    endcase
  end

  // Datapath: header capture, word assembly, idle timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= 16'd0;
      r_byteCnt <= 2'd0;
      r_word    <= 24'd0;
      r_idle    <= '0;
      r_loaded  <= 16'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_coreRst <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_transfer || !w_inTimedState) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + c_IDLE_W'(1);
      end

      if (w_transfer && (r_state == c_stHdr0)) begin
        r_count[7:0] <= byte_data;
      end
      if (w_transfer && (r_state == c_stHdr1)) begin
        r_count[15:8] <= byte_data;
      end

      if (w_transfer && (r_state == c_stData)) begin
        r_byteCnt <= r_byteCnt + 2'd1;
        case (r_byteCnt)
          2'd0:    r_word[7:0]   <= byte_data;
          2'd1:    r_word[15:8]  <= byte_data;
          2'd2:    r_word[23:16] <= byte_data;
          default: r_word        <= r_word;
        endcase
      end

      r_we <= w_lastByte;
      if (w_lastByte) begin
        r_wdata  <= {byte_data, r_word};
        r_addr   <= {14'd0, r_loaded, 2'b00};
        r_loaded <= w_loadedNext;
      end

      // DONE and ERROR are absorbing, so these flags stay put until rst.
      r_coreRst <= (r_state != c_stDone);
      r_done    <= (r_state == c_stDone);
      r_error   <= (r_state == c_stError);
    end
  end

  assign byte_ready   = w_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_rst     = r_coreRst;
  assign done         = r_done;
  assign error        = r_error;
  assign loaded_words = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [15:0] loaded_words;

  int errors = 0;
  int checks = 0;

  logic [31:0] wrAddr [16];
  logic [31:0] wrData [16];
  int          wrN = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        crst;
    logic        dn;
    logic        err;
    logic [15:0] loaded;
  } vec_t;

  vec_t vecs [12];

  imem_boot_loader #(.DEPTH_WORDS(256), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .loaded_words (loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      if (wrN < 16) begin
        wrAddr[wrN] = imem_addr;
        wrData[wrN] = imem_wdata;
      end
      wrN = wrN + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                              input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic cr, input logic dn, input logic er,
                              input logic [15:0] lw);
    vec_t r;
    r.valid = v; r.data = d; r.ready = rdy; r.we = we; r.addr = a; r.wdata = wd;
    r.crst = cr; r.dn = dn; r.err = er; r.loaded = lw;
    return r;
  endfunction

  // Starts and ends at a falling edge of clk.
  task automatic doReset();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rst        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wrN = 0;
  endtask

  // Called at a falling edge; holds valid until one transfer has occurred.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_ready_wait: got ready=0 expected ready=1 within 20 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1;
    chk("reset_ready",    {31'd0, byte_ready}, 32'd1);
    chk("reset_we",       {31'd0, imem_we},    32'd0);
    chk("reset_addr",     imem_addr,           32'd0);
    chk("reset_wdata",    imem_wdata,          32'd0);
    chk("reset_core_rst", {31'd0, core_rst},   32'd1);
    chk("reset_done",     {31'd0, done},       32'd0);
    chk("reset_error",    {31'd0, error},      32'd0);
    chk("reset_loaded",   {16'd0, loaded_words}, 32'd0);

    // Back-to-back image: count=2, 0x12345678 then 0xDEADBEEF.
    //                v     data   rdy we  addr   wdata          crst dn er loaded
    vecs[0]  = mk(1'b1, 8'h02, 1, 0, 32'h0, 32'h0,        1, 0, 0, 16'd0);
    vecs[1]  = mk(1'b1, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0, 16'd0);
    vecs[2]  = mk(1'b1, 8'h78, 1, 0, 32'h0, 32'h0,        1, 0, 0, 16'd0);
    vecs[3]  = mk(1'b1, 8'h56, 1, 0, 32'h0, 32'h0,        1, 0, 0, 16'd0);
    vecs[4]  = mk(1'b1, 8'h34, 1, 0, 32'h0, 32'h0,        1, 0, 0, 16'd0);
    vecs[5]  = mk(1'b1, 8'h12, 1, 1, 32'h0, 32'h12345678, 1, 0, 0, 16'd1);
    vecs[6]  = mk(1'b1, 8'hEF, 1, 0, 32'h0, 32'h12345678, 1, 0, 0, 16'd1);
    vecs[7]  = mk(1'b1, 8'hBE, 1, 0, 32'h0, 32'h12345678, 1, 0, 0, 16'd1);
    vecs[8]  = mk(1'b1, 8'hAD, 1, 0, 32'h0, 32'h12345678, 1, 0, 0, 16'd1);
    vecs[9]  = mk(1'b1, 8'hDE, 0, 1, 32'h4, 32'hDEADBEEF, 1, 0, 0, 16'd2);
    vecs[10] = mk(1'b0, 8'h00, 0, 0, 32'h4, 32'hDEADBEEF, 0, 1, 0, 16'd2);
    vecs[11] = mk(1'b1, 8'h55, 0, 0, 32'h4, 32'hDEADBEEF, 0, 1, 0, 16'd2);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      byte_valid = vecs[i].valid;
      byte_data  = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ready", i),  {31'd0, byte_ready},    {31'd0, vecs[i].ready});
      chk($sformatf("vec%0d_we", i),     {31'd0, imem_we},       {31'd0, vecs[i].we});
      chk($sformatf("vec%0d_addr", i),   imem_addr,              vecs[i].addr);
      chk($sformatf("vec%0d_wdata", i),  imem_wdata,             vecs[i].wdata);
      chk($sformatf("vec%0d_crst", i),   {31'd0, core_rst},      {31'd0, vecs[i].crst});
      chk($sformatf("vec%0d_done", i),   {31'd0, done},          {31'd0, vecs[i].dn});
      chk($sformatf("vec%0d_error", i),  {31'd0, error},         {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_loaded", i), {16'd0, loaded_words},  {16'd0, vecs[i].loaded});
      @(negedge clk);
    end
    byte_valid = 1'b0;

    // Empty image: done two edges after the second header byte.
    doReset();
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    chk("zero_ready_h",    {31'd0, byte_ready}, 32'd0);
    chk("zero_crst_h",     {31'd0, core_rst},   32'd1);
    chk("zero_done_h",     {31'd0, done},       32'd0);
    @(negedge clk);
    chk("zero_crst_h1",    {31'd0, core_rst},   32'd0);
    chk("zero_done_h1",    {31'd0, done},       32'd1);
    chk("zero_writes",     wrN,                 32'd0);

    // Oversize image: count = 257.
    doReset();
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    chk("big_ready",       {31'd0, byte_ready}, 32'd0);
    chk("big_error_early", {31'd0, error},      32'd0);
    @(negedge clk);
    chk("big_error",       {31'd0, error},      32'd1);
    chk("big_crst",        {31'd0, core_rst},   32'd1);
    repeat (3) @(negedge clk);
    chk("big_crst_held",   {31'd0, core_rst},   32'd1);
    chk("big_done",        {31'd0, done},       32'd0);
    chk("big_writes",      wrN,                 32'd0);

    // Timeout after 8 idle cycles mid-word.
    doReset();
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    repeat (7) @(negedge clk);
    chk("to_ready_7idle",  {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    chk("to_ready_8idle",  {31'd0, byte_ready}, 32'd0);
    chk("to_error_early",  {31'd0, error},      32'd0);
    @(negedge clk);
    chk("to_error",        {31'd0, error},      32'd1);
    chk("to_crst",         {31'd0, core_rst},   32'd1);
    chk("to_writes",       wrN,                 32'd0);

    // Byte arriving on the 8th idle cycle is accepted.
    doReset();
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    repeat (7) @(negedge clk);
    sendByte(8'hCC, 0);
    sendByte(8'hDD, 0);
    waitDone("late_done_wait");
    @(negedge clk);
    chk("late_error",      {31'd0, error},      32'd0);
    chk("late_writes",     wrN,                 32'd1);
    chk("late_wdata",      wrData[0],           32'hDDCCBBAA);
    chk("late_addr",       wrAddr[0],           32'h0);

    // Random gaps below the timeout on a 4-word image.
    doReset();
    sendByte(8'h04, $urandom_range(0, 7));
    sendByte(8'h00, $urandom_range(0, 7));
    for (int i = 1; i <= 16; i++) begin
      sendByte(8'(i), $urandom_range(0, 7));
    end
    waitDone("gap_done_wait");
    @(negedge clk);
    chk("gap_error",       {31'd0, error},      32'd0);
    chk("gap_writes",      wrN,                 32'd4);
    chk("gap_loaded",      {16'd0, loaded_words}, 32'd4);
    chk("gap_addr0",  wrAddr[0], 32'h0);
    chk("gap_data0",  wrData[0], 32'h04030201);
    chk("gap_addr1",  wrAddr[1], 32'h4);
    chk("gap_data1",  wrData[1], 32'h08070605);
    chk("gap_addr2",  wrAddr[2], 32'h8);
    chk("gap_data2",  wrData[2], 32'h0C0B0A09);
    chk("gap_addr3",  wrAddr[3], 32'hC);
    chk("gap_data3",  wrData[3], 32'h100F0E0D);

    // Reset mid-load, then a fresh one-word image.
    doReset();
    sendByte(8'h03, 0);
    sendByte(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      sendByte(8'hA0 + 8'(i), 0);
    end
    chk("mid_loaded_pre",  {16'd0, loaded_words}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_ready",       {31'd0, byte_ready}, 32'd1);
    chk("mid_we",          {31'd0, imem_we},    32'd0);
    chk("mid_addr",        imem_addr,           32'd0);
    chk("mid_wdata",       imem_wdata,          32'd0);
    chk("mid_crst",        {31'd0, core_rst},   32'd1);
    chk("mid_loaded",      {16'd0, loaded_words}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wrN = 0;
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'h44, 0);
    sendByte(8'h33, 0);
    sendByte(8'h22, 0);
    sendByte(8'h11, 0);
    waitDone("reload_done_wait");
    chk("reload_error",    {31'd0, error},      32'd0);
    chk("reload_crst",     {31'd0, core_rst},   32'd0);
    chk("reload_writes",   wrN,                 32'd1);
    chk("reload_addr",     wrAddr[0],           32'h0);
    chk("reload_wdata",    wrData[0],           32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream boot loader that sits directly upstream of the pipelined MIPS core's fetch stage. It receives a length-prefixed program image over a valid/ready byte interface and assembles little-endian 32-bit words. It writes them sequentially into instruction memory from address 0 and holds the core in reset until the image is fully written. Load failures (oversize image, stalled stream) are reported and latched until reset.

## Interface
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; image lengths above this are rejected
- TIMEOUT, 65535, max consecutive idle cycles allowed mid-image (HDR1/DATA) before error; must be ≥ 1
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- byte_valid  input  1  source presents byte_data
- byte_data  input  8  image byte
- byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready
- imem_we  output  1  one-cycle instruction memory write strobe
- imem_addr  output  32  byte address of the write, word aligned (word_index*4)
- imem_wdata  output  32  assembled word
- core_rst  output  1  reset to the pipeline; high until load completes
- done  output  1  image loaded, sticky until rst
- error  output  1  load failed, sticky until rst
- loaded_words  output  16  number of words written so far

## Operation
- States: HDR0 (wait count low byte), HDR1 (count high byte), DATA, DONE, ERROR.
- byte_ready = 1 in HDR0/HDR1/DATA, 0 in DONE/ERROR (decoded from state register).
- HDR0: on transfer, store count[7:0] -> HDR1. No timeout in HDR0; it waits indefinitely.
- HDR1: on transfer, count[15:8] = byte. If count == 0 -> DONE. If count > DEPTH_WORDS -> ERROR. Otherwise -> DATA.
- DATA: bytes placed little-endian; the first byte of a word goes to [7:0] and the fourth to [31:24]. A 2-bit byte counter wraps 3 -> 0.
- On the transfer of the 4th byte: register imem_wdata = assembled word, imem_addr = loaded_words*4, imem_we = 1, loaded_words += 1. If the new loaded_words == count -> DONE.
- Timeout: idle counter cleared on every transfer and on entry to HDR1/DATA. It increments each HDR1/DATA cycle without a transfer. When TIMEOUT consecutive idle cycles elapse -> ERROR. A transfer on the would-be timeout cycle wins: it is accepted and the counter clears.
- ERROR: sets error = 1 and core_rst stays 1. Any partial word is discarded and imem_we stays 0. Exit only via rst.
- DONE: done = 1, core_rst = 0. Further bytes are not accepted. Exit only via rst.
- Previously written memory contents are never cleared by the loader.

## Timing
- Reset values (asynchronous, immediate): state HDR0, byte_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, done 0, error 0, loaded_words 0, all counters 0.
- Sources must not assert byte_valid while rst is high.
- Write latency: the edge accepting the 4th byte (E) drives imem_we high for exactly the cycle after E. imem_addr/imem_wdata hold their values until the next write.
- Completion: state becomes DONE at edge E. At edge E+1: imem_we = 0, core_rst falls, done rises. The core therefore leaves reset only after the final write has been committed.
- Count == 0: at the HDR1 transfer edge H the state becomes DONE; core_rst = 0 and done = 1 at H+1.
- Oversize / timeout: error rises on the edge after entering ERROR; core_rst never falls.
- Back-to-back bytes at one per cycle are sustained, with no bubbles between words.
- rst mid-load: everything returns asynchronously to reset values, including an imem_we pulse in flight (cut off). The next image restarts at HDR0 and address 0.

## Test plan
- Image count=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE, one per cycle -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, each imem_we one cycle. done=1, core_rst=0 one cycle after the second write; loaded_words=2.
- Count=0 (00 00) -> no imem_we; done=1, core_rst=0 two edges after the 2nd header byte; byte_ready=0 afterwards.
- Count=257 with DEPTH_WORDS=256 (01 01) -> ERROR, error=1, byte_ready=0, core_rst stays 1, no writes.
- TIMEOUT=8, count=1, send 2 data bytes then idle 8 cycles -> error=1, no imem_we. Repeat with the byte arriving on the 8th idle cycle -> accepted, no error.
- Random byte_valid gaps (< TIMEOUT) on a 4-word image -> same memory contents as the back-to-back case, addresses 0,4,8,C.
- Assert rst after 6 data bytes of a 3-word image, then reload count=1 image 44 33 22 11 -> single write 0x11223344 @0x0; done=1, error=0.
